// File: rtl/cva6_boot_ctrl.sv
`default_nettype none
// ============================================================================
// cva6_boot_ctrl : reset/boot sequencer for the CVA6 hart (reset hold, boot
//                  select, debug halt, drained soft reset with timeout).
// Optional feature macro: CVA6_BOOT_CTRL_RST_CNT_EN (soft reset counter).
// Revision: 1.0
// ============================================================================
module cva6_boot_ctrl #(
  parameter int unsigned          AddrWidth     = 64,
  parameter int unsigned          RstHoldCycles = 16,
  parameter int unsigned          IdleTimeout   = 1024,
  parameter logic [AddrWidth-1:0] BootRomAddr   = 64'h0000_0000_1A00_0000,
  parameter logic [AddrWidth-1:0] CodeZoneAddr  = 64'h0000_0000_8000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           boot_sel_i,
  input  logic                 soft_rst_req_i,
  output logic                 soft_rst_ack_o,
  input  logic                 axi_idle_i,
  input  logic                 core_halted_i,
  input  logic                 timeout_clr_i,
  output logic                 core_rst_no,
  output logic [AddrWidth-1:0] boot_addr_o,
  output logic                 debug_req_o,
  output logic [2:0]           state_o,
`ifdef CVA6_BOOT_CTRL_RST_CNT_EN
  output logic [7:0]           soft_rst_cnt_o,
`endif
  output logic                 timeout_o
);

  localparam logic [2:0] RESET_HOLD = 3'd0;
  localparam logic [2:0] SAMPLE     = 3'd1;
  localparam logic [2:0] HALT_REQ   = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] DRAIN      = 3'd4;

  localparam int unsigned CNT_MAX = (RstHoldCycles > IdleTimeout) ? RstHoldCycles : IdleTimeout;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RstHoldCycles - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IdleTimeout - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             drain_exit;
  logic             drain_timeout;
  logic             core_live_next;

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    drain_exit    = 1'b0;
    drain_timeout = 1'b0;
    case (state)
      RESET_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_next = SAMPLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      SAMPLE: begin
        state_next = (boot_sel_i == 2'd1) ? HALT_REQ : RUN;
      end
      HALT_REQ: begin
        // A soft reset request outranks the halt acknowledge.
        if (soft_rst_req_i) begin
          state_next = DRAIN;
        end else if (core_halted_i) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (soft_rst_req_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Idle is checked first so a coincident timeout leaves timeout_o alone.
        if (axi_idle_i) begin
          state_next = RESET_HOLD;
          cnt_next   = '0;
          drain_exit = 1'b1;
        end else if (cnt == IDLE_LAST) begin
          state_next    = RESET_HOLD;
          cnt_next      = '0;
          drain_exit    = 1'b1;
          drain_timeout = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = RESET_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  assign core_live_next = (state_next != RESET_HOLD) && (state_next != SAMPLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= RESET_HOLD;
      cnt            <= '0;
      core_rst_no    <= 1'b0;
      debug_req_o    <= 1'b0;
      soft_rst_ack_o <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      core_rst_no    <= core_live_next;
      debug_req_o    <= (state_next == HALT_REQ);
      soft_rst_ack_o <= drain_exit;
      if (drain_timeout) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

  // Boot address is only captured while the core is still held in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_addr_o <= BootRomAddr;
    end else if (state == SAMPLE) begin
      boot_addr_o <= (boot_sel_i == 2'd2) ? CodeZoneAddr : BootRomAddr;
    end
  end

`ifdef CVA6_BOOT_CTRL_RST_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      soft_rst_cnt_o <= 8'd0;
    end else if (drain_exit && (soft_rst_cnt_o != 8'hFF)) begin
      soft_rst_cnt_o <= soft_rst_cnt_o + 8'd1;
    end
  end
`endif

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_cva6_boot_ctrl.sv
`default_nettype none
// Testbench for cva6_boot_ctrl: randomized boot/soft-reset sequences against
// a cycle-count reference model; covers CVA6_BOOT_CTRL_RST_CNT_EN when defined.
module tb_cva6_boot_ctrl;

  localparam int unsigned AW   = 64;
  localparam int unsigned HOLD = 16;
  localparam int unsigned TMO  = 1024;
  localparam logic [AW-1:0] ROM  = 64'h0000_0000_1A00_0000;
  localparam logic [AW-1:0] CODE = 64'h0000_0000_8000_0000;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [1:0]    boot_sel_i = 2'd0;
  logic          soft_rst_req_i = 1'b0;
  logic          soft_rst_ack_o;
  logic          axi_idle_i = 1'b0;
  logic          core_halted_i = 1'b0;
  logic          timeout_clr_i = 1'b0;
  logic          core_rst_no;
  logic [AW-1:0] boot_addr_o;
  logic          debug_req_o;
  logic [2:0]    state_o;
  logic          timeout_o;
`ifdef CVA6_BOOT_CTRL_RST_CNT_EN
  logic [7:0]    soft_rst_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  logic exp_to = 1'b0;
  int   n_acks = 0;

  cva6_boot_ctrl #(
    .AddrWidth    (AW),
    .RstHoldCycles(HOLD),
    .IdleTimeout  (TMO),
    .BootRomAddr  (ROM),
    .CodeZoneAddr (CODE)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .boot_sel_i    (boot_sel_i),
    .soft_rst_req_i(soft_rst_req_i),
    .soft_rst_ack_o(soft_rst_ack_o),
    .axi_idle_i    (axi_idle_i),
    .core_halted_i (core_halted_i),
    .timeout_clr_i (timeout_clr_i),
    .core_rst_no   (core_rst_no),
    .boot_addr_o   (boot_addr_o),
    .debug_req_o   (debug_req_o),
    .state_o       (state_o),
`ifdef CVA6_BOOT_CTRL_RST_CNT_EN
    .soft_rst_cnt_o(soft_rst_cnt_o),
`endif
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_addr(input logic [1:0] sel);
    return (sel == 2'd2) ? CODE : ROM;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 64'(state_o), 64'd0);
    chk({tag, "_rstn"},  64'(core_rst_no), 64'd0);
    chk({tag, "_addr"},  boot_addr_o, ROM);
    chk({tag, "_dbg"},   64'(debug_req_o), 64'd0);
    chk({tag, "_ack"},   64'(soft_rst_ack_o), 64'd0);
    chk({tag, "_tmo"},   64'(timeout_o), 64'd0);
`ifdef CVA6_BOOT_CTRL_RST_CNT_EN
    chk({tag, "_cnt"},   64'(soft_rst_cnt_o), 64'd0);
`endif
  endtask

  // Caller is 1 time unit after the edge that entered the reset hold
  // (or after reset release); n0 edges of the hold have already elapsed.
  task automatic do_boot(input logic [1:0] sel, input int n0);
    int n;
    int k;
    n = n0;
    boot_sel_i = sel;
    while (core_rst_no !== 1'b1 && n < 4 * HOLD + 20) begin
      tick();
      n++;
    end
    chk("boot_latency", 64'(n), 64'(HOLD + 1));
    chk("boot_addr", boot_addr_o, model_addr(sel));
    chk("boot_state", 64'(state_o), (sel == 2'd1) ? 64'd2 : 64'd3);
    chk("boot_dbg", 64'(debug_req_o), (sel == 2'd1) ? 64'd1 : 64'd0);
    if (sel == 2'd1) begin
      k = int'($urandom_range(1, 8));
      repeat (k) tick();
      chk("halt_wait_dbg", 64'(debug_req_o), 64'd1);
      chk("halt_wait_state", 64'(state_o), 64'd2);
      core_halted_i = 1'b1;
      tick();
      core_halted_i = 1'b0;
      chk("halt_done_dbg", 64'(debug_req_o), 64'd0);
      chk("halt_done_state", 64'(state_o), 64'd3);
    end
  endtask

  // Soft reset with the AXI master going idle after idle_k DRAIN cycles,
  // then a re-boot with boot select next_sel.
  task automatic soft_reset(input int idle_k, input logic clr_hold, input logic [1:0] next_sel);
    int n;
    int exp_n;
    logic to_hit;
    axi_idle_i = 1'b0;
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    chk("drain_state", 64'(state_o), 64'd4);
    chk("drain_rstn", 64'(core_rst_no), 64'd1);
    chk("drain_dbg", 64'(debug_req_o), 64'd0);
    timeout_clr_i = clr_hold;
    n = 0;
    while (soft_rst_ack_o !== 1'b1 && n < TMO + 20) begin
      axi_idle_i = (n >= idle_k);
      tick();
      n++;
    end
    timeout_clr_i = 1'b0;
    axi_idle_i = 1'b0;
    to_hit = (idle_k >= int'(TMO));
    exp_n  = (idle_k < int'(TMO) - 1) ? idle_k + 1 : int'(TMO);
    if (to_hit)        exp_to = 1'b1;
    else if (clr_hold) exp_to = 1'b0;
    n_acks++;
    chk("drain_cycles", 64'(n), 64'(exp_n));
    chk("ack_rstn", 64'(core_rst_no), 64'd0);
    chk("ack_state", 64'(state_o), 64'd0);
    chk("ack_timeout", 64'(timeout_o), 64'(exp_to));
`ifdef CVA6_BOOT_CTRL_RST_CNT_EN
    chk("ack_count", 64'(soft_rst_cnt_o), 64'((n_acks > 255) ? 255 : n_acks));
`endif
    // A request while the core is held in reset must be ignored.
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    chk("ack_pulse_end", 64'(soft_rst_ack_o), 64'd0);
    do_boot(next_sel, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] sel;
    logic [AW-1:0] held_addr;

    // Reset state
    rst_ni = 1'b0;
    repeat (3) tick();
    chk_reset_values("reset");
    rst_ni = 1'b1;
    do_boot(2'd0, 0);

    // Debug-halt boot and randomized boots through soft resets with idle AXI
    soft_reset(0, 1'b0, 2'd1);
    for (int i = 0; i < 6; i++) begin
      sel = 2'($urandom_range(0, 3));
      soft_reset(int'($urandom_range(0, 40)), 1'b0, sel);
    end

    // Boot select changes while running do not disturb boot_addr_o
    soft_reset(0, 1'b0, 2'd2);
    held_addr = boot_addr_o;
    chk("code_zone_addr", held_addr, CODE);
    boot_sel_i = 2'd0;
    repeat (7) tick();
    chk("addr_stable_run", boot_addr_o, CODE);
    soft_reset(3, 1'b0, 2'd0);
    chk("addr_after_resample", boot_addr_o, ROM);

    // Timeout boundaries: idle coincident with last count, then true timeout
    soft_reset(int'(TMO) - 1, 1'b0, 2'd0);
    soft_reset(int'(TMO) + 5, 1'b0, 2'd3);
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    exp_to = 1'b0;
    chk("timeout_cleared", 64'(timeout_o), 64'd0);
    // Clear held through a timing-out drain: set wins
    soft_reset(int'(TMO) + 1, 1'b1, 2'd0);

    // Async reset in the middle of a drain
    axi_idle_i = 1'b0;
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    repeat (5) tick();
    #2 rst_ni = 1'b0;
    #1;
    exp_to = 1'b0;
    n_acks = 0;
    chk_reset_values("midreset");
    repeat (3) tick();
    chk("midreset_no_ack", 64'(soft_rst_ack_o), 64'd0);
    rst_ni = 1'b1;
    do_boot(2'($urandom_range(0, 3)), 0);

`ifdef CVA6_BOOT_CTRL_RST_CNT_EN
    for (int i = 0; i < 300; i++) begin
      soft_reset(0, 1'b0, 2'd0);
    end
    chk("count_saturated", 64'(soft_rst_cnt_o), 64'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
